// File: rtl/demux_grant_scheduler_pkg.sv
// Shared types and sizes for the demux grant scheduler.
// Holds state encodings, requester count and field widths.
package demux_grant_scheduler_pkg;

  localparam int NUM_REQ = 16;
  localparam int SEL_W   = 4;
  localparam int HOLD_W  = 5;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StOwn  = 2'd1;
  localparam state_t StGap  = 2'd2;

endpackage

// File: rtl/demux_grant_scheduler_rr_pick.sv
// Round-robin picker: first set Req bit at or above Start, wrapping.
// Ports: Req, Start in; Found, Index out (purely combinational).
module rr_pick_16
  import demux_grant_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] Req,
  input  logic [SEL_W-1:0]   Start,
  output logic               Found,
  output logic [SEL_W-1:0]   Index
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    Found = 1'b0;
    Index = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = Start + SEL_W'(i);
      if (!Found && Req[cand]) begin
        Found = 1'b1;
        Index = cand;
      end
    end
  end

endmodule

// File: rtl/demux_grant_scheduler.sv
// Round-robin owner scheduler driving a demux select/enable.
// Ports: Clock, Reset, Req, Release in; Sel, Enable, Grant, Busy out.
module demux_grant_scheduler
  import demux_grant_scheduler_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] Req,
  input  logic               Release,
  output logic [SEL_W-1:0]   Sel,
  output logic               Enable,
  output logic [NUM_REQ-1:0] Grant,
  output logic               Busy
);

  localparam logic [HOLD_W-1:0] HoldLast =
    HOLD_W'(MAX_HOLD - 1);

  state_t            state;
  logic [SEL_W-1:0]  lastSel;
  logic [HOLD_W-1:0] hold;

  logic              found;
  logic [SEL_W-1:0]  winner;
  logic              ownExit;

  rr_pick_16 uPick (
    .Req   (Req),
    .Start (lastSel + SEL_W'(1)),
    .Found (found),
    .Index (winner)
  );

  assign ownExit = Release || !Req[Sel] || (hold == HoldLast);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= StIdle;
      Sel     <= '0;
      lastSel <= SEL_W'(NUM_REQ - 1);
      hold    <= '0;
      Enable  <= 1'b0;
      Grant   <= '0;
      Busy    <= 1'b0;
    end else begin
      case (state)
        StIdle, StGap: begin
          if (found) begin
            state  <= StOwn;
            Sel    <= winner;
            hold   <= '0;
            Enable <= 1'b1;
            Grant  <= NUM_REQ'(1) << winner;
            Busy   <= 1'b1;
          end else begin
            state  <= StIdle;
            Enable <= 1'b0;
            Grant  <= '0;
            Busy   <= 1'b0;
          end
        end
        StOwn: begin
          if (ownExit) begin
            // Sel is held through the dead cycle; only LastSel moves.
            state   <= StGap;
            lastSel <= Sel;
            Enable  <= 1'b0;
            Grant   <= '0;
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        default: begin
          state  <= StIdle;
          Enable <= 1'b0;
          Grant  <= '0;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_grant_scheduler.sv
// Directed self-checking bench for demux_grant_scheduler.
// Two instances: MAX_HOLD=8 and MAX_HOLD=1, sharing inputs.
module tb_demux_grant_scheduler;

  logic        Clock;
  logic        Reset;
  logic [15:0] Req;
  logic        Release;

  logic [3:0]  Sel;
  logic        Enable;
  logic [15:0] Grant;
  logic        Busy;

  logic [3:0]  Sel1;
  logic        Enable1;
  logic [15:0] Grant1;
  logic        Busy1;

  int checks;
  int errors;

  demux_grant_scheduler #(.MAX_HOLD(8)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Req     (Req),
    .Release (Release),
    .Sel     (Sel),
    .Enable  (Enable),
    .Grant   (Grant),
    .Busy    (Busy)
  );

  demux_grant_scheduler #(.MAX_HOLD(1)) dut1 (
    .Clock   (Clock),
    .Reset   (Reset),
    .Req     (Req),
    .Release (Release),
    .Sel     (Sel1),
    .Enable  (Enable1),
    .Grant   (Grant1),
    .Busy    (Busy1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    Reset   = 1'b1;
    Req     = '0;
    Release = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset   = 1'b0;
    Req     = '0;
    Release = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({Sel, Enable, Grant, Busy} !== 22'd0) begin
      errors++;
      $display("FAIL reset_async: got sel=%0d en=%b g=%h busy=%b want 0",
               Sel, Enable, Grant, Busy);
    end
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if ({Sel, Enable, Grant, Busy} !== 22'd0) begin
      errors++;
      $display("FAIL reset_idle: got sel=%0d en=%b g=%h busy=%b want 0",
               Sel, Enable, Grant, Busy);
    end
  endtask

  task automatic test_sole();
    do_reset();
    Req = 16'h0001;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clock);
      checks++;
      if (Enable !== 1'b1 || Sel !== 4'd0 || Grant !== 16'h0001) begin
        errors++;
        $display("FAIL sole_own[%0d]: got en=%b sel=%0d g=%h want 1/0/0001",
                 c, Enable, Sel, Grant);
      end
    end
    @(negedge Clock);
    checks++;
    if (Enable !== 1'b0 || Grant !== 16'h0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL sole_gap: got en=%b g=%h busy=%b want 0/0000/1",
               Enable, Grant, Busy);
    end
    @(negedge Clock);
    checks++;
    if (Enable !== 1'b1 || Sel !== 4'd0 || Grant !== 16'h0001) begin
      errors++;
      $display("FAIL sole_regrant: got en=%b sel=%0d g=%h want 1/0/0001",
               Enable, Sel, Grant);
    end
  endtask

  task automatic test_release();
    logic [3:0]  expSel;
    logic [15:0] expGrant;
    do_reset();
    Req = 16'h8001;
    for (int t = 0; t < 4; t++) begin
      expSel   = (t % 2 == 0) ? 4'd0 : 4'd15;
      expGrant = 16'h0001 << expSel;
      for (int k = 1; k <= 3; k++) begin
        @(negedge Clock);
        checks++;
        if (Enable !== 1'b1 || Sel !== expSel || Grant !== expGrant) begin
          errors++;
          $display("FAIL release_own[%0d.%0d]: got en=%b sel=%0d g=%h want 1/%0d/%h",
                   t, k, Enable, Sel, Grant, expSel, expGrant);
        end
        if (k == 3) Release = 1'b1;
      end
      @(negedge Clock);
      Release = 1'b0;
      checks++;
      if (Enable !== 1'b0 || Grant !== 16'h0 || Busy !== 1'b1 ||
          Sel !== expSel) begin
        errors++;
        $display("FAIL release_gap[%0d]: got en=%b g=%h busy=%b sel=%0d want 0/0000/1/%0d",
                 t, Enable, Grant, Busy, Sel, expSel);
      end
    end
  endtask

  task automatic test_maxhold1();
    logic [3:0] expSel;
    do_reset();
    Req = 16'hFFFF;
    for (int n = 0; n < 17; n++) begin
      expSel = 4'(n % 16);
      @(negedge Clock);
      checks++;
      if (Enable1 !== 1'b1 || Sel1 !== expSel ||
          Grant1 !== (16'h0001 << expSel)) begin
        errors++;
        $display("FAIL mh1_own[%0d]: got en=%b sel=%0d g=%h want 1/%0d",
                 n, Enable1, Sel1, Grant1, expSel);
      end
      @(negedge Clock);
      checks++;
      if (Enable1 !== 1'b0 || Grant1 !== 16'h0) begin
        errors++;
        $display("FAIL mh1_gap[%0d]: got en=%b g=%h want 0/0000",
                 n, Enable1, Grant1);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    Req = 16'h0220;
    @(negedge Clock);
    checks++;
    if (Enable !== 1'b1 || Sel !== 4'd5 || Grant !== 16'h0020) begin
      errors++;
      $display("FAIL drop_first: got en=%b sel=%0d g=%h want 1/5/0020",
               Enable, Sel, Grant);
    end
    Req = 16'h1228;
    @(negedge Clock);
    checks++;
    if (Enable !== 1'b1 || Sel !== 4'd5 || Grant !== 16'h0020) begin
      errors++;
      $display("FAIL drop_other_bits: got en=%b sel=%0d g=%h want 1/5/0020",
               Enable, Sel, Grant);
    end
    Req = 16'h0200;
    @(negedge Clock);
    checks++;
    if (Enable !== 1'b0 || Grant !== 16'h0 || Sel !== 4'd5) begin
      errors++;
      $display("FAIL drop_gap: got en=%b g=%h sel=%0d want 0/0000/5",
               Enable, Grant, Sel);
    end
    @(negedge Clock);
    checks++;
    if (Enable !== 1'b1 || Sel !== 4'd9 || Grant !== 16'h0200) begin
      errors++;
      $display("FAIL drop_next: got en=%b sel=%0d g=%h want 1/9/0200",
               Enable, Sel, Grant);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Req = 16'h0080;
    @(negedge Clock);
    @(negedge Clock);
    checks++;
    if (Enable !== 1'b1 || Sel !== 4'd7) begin
      errors++;
      $display("FAIL rmid_own: got en=%b sel=%0d want 1/7", Enable, Sel);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (Enable !== 1'b0 || Grant !== 16'h0 || Busy !== 1'b0 ||
        Sel !== 4'd0) begin
      errors++;
      $display("FAIL rmid_async: got en=%b g=%h busy=%b sel=%0d want 0/0000/0/0",
               Enable, Grant, Busy, Sel);
    end
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if (Enable !== 1'b1 || Sel !== 4'd7 || Grant !== 16'h0080) begin
      errors++;
      $display("FAIL rmid_regrant: got en=%b sel=%0d g=%h want 1/7/0080",
               Enable, Sel, Grant);
    end
  endtask

  task automatic test_gap_idle();
    do_reset();
    Req = 16'h0001;
    @(negedge Clock);
    Req = 16'h0000;
    @(negedge Clock);
    checks++;
    if (Enable !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL gi_gap: got en=%b busy=%b want 0/1", Enable, Busy);
    end
    @(negedge Clock);
    checks++;
    if (Enable !== 1'b0 || Busy !== 1'b0 || Grant !== 16'h0) begin
      errors++;
      $display("FAIL gi_idle: got en=%b busy=%b g=%h want 0/0/0000",
               Enable, Busy, Grant);
    end
    @(negedge Clock);
    Req = 16'h0400;
    @(negedge Clock);
    checks++;
    if (Enable !== 1'b1 || Sel !== 4'd10 || Grant !== 16'h0400 ||
        Busy !== 1'b1) begin
      errors++;
      $display("FAIL gi_regrant: got en=%b sel=%0d g=%h busy=%b want 1/10/0400/1",
               Enable, Sel, Grant, Busy);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    Reset   = 1'b0;
    Req     = '0;
    Release = 1'b0;
    test_reset();
    test_sole();
    test_release();
    test_maxhold1();
    test_drop();
    test_reset_mid();
    test_gap_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_grant_scheduler.md
DEMUX_GRANT_SCHEDULER -- requirements
Module: demux_grant_scheduler

Interface
REQ-001 Parameter MAX_HOLD, default 8, meaning maximum consecutive OWN cycles per grant; SHALL be legal in range 1..16.
REQ-002 Clock  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Req  input  16  request vector; bit i asserted means requester i wants the demux path.
REQ-005 Release  input  1  owner done; sampled only in OWN.
REQ-006 Sel  output  4  registered index of the current owner; drives the demux select.
REQ-007 Enable  output  1  registered; high only in OWN; drives the demux enable.
REQ-008 Grant  output  16  registered one-hot of Sel while Enable=1; all-zero otherwise.
REQ-009 Busy  output  1  registered; high in OWN and GAP.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, OWN and GAP.
REQ-011 IDLE: if Req==0, stay in IDLE; otherwise go to OWN at the next edge with Sel = winner.
REQ-012 Winner SHALL be the first set Req bit searching upward from (LastSel+1) mod 16 and wrapping (round-robin).
REQ-013 Grant latency SHALL be one cycle: Req seen at edge N, so Enable=1 and Grant valid after edge N.
REQ-014 OWN: the hold counter SHALL be 0 in the first OWN cycle and increment by 1 each further OWN cycle.
REQ-015 OWN exits to GAP at the next edge when any of these holds: Release=1; Req[Sel]=0; or hold counter == MAX_HOLD-1.
REQ-016 On OWN exit, LastSel SHALL load Sel.
REQ-017 Sel SHALL remain stable for the whole OWN tenure and through GAP.
REQ-018 GAP SHALL last exactly one cycle with Enable=0 and Grant=0 (dead cycle between owners).
REQ-019 GAP: if Req!=0, go to OWN with a new winner per REQ-012; otherwise go to IDLE.
REQ-020 A sole requester that keeps Req asserted SHALL be re-granted after each GAP, giving a pattern of MAX_HOLD cycles on and 1 cycle off.
REQ-021 Req changes on bits other than Sel during OWN SHALL NOT affect the current grant.
REQ-022 MAX_HOLD=1 SHALL force every grant to last exactly one cycle.

Reset
REQ-023 Reset asserted SHALL immediately force: state=IDLE, Sel=0, Enable=0, Grant=0, Busy=0, hold counter=0, LastSel=15.
REQ-024 Reset mid-OWN SHALL drop Enable and Grant asynchronously, without a GAP cycle.
REQ-025 After Reset deasserts, the first search SHALL start at requester 0.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE/OWN/GAP), the requester count (16), the select width (4) and the hold-counter width (5).
REQ-027 The round-robin search SHALL be a combinational sub-module rr_pick_16 with inputs Req[15:0] and Start[3:0], and outputs Found and Index[3:0].
REQ-028 All outputs SHALL come directly from flops; there SHALL be no combinational path from Req or Release to any output.

Verification
REQ-029 Reset, then Req=16'h0001 held with MAX_HOLD=8 -> one cycle later Enable=1, Sel=0, Grant=16'h0001 for 8 cycles, then 1 GAP cycle, then the grant repeats.
REQ-030 Req=16'h8001 held after reset, with Release pulsed on the 3rd OWN cycle of each grant -> grant order 0, 15, 0, 15, each tenure 3 cycles, GAP between each.
REQ-031 Req=16'hFFFF held with MAX_HOLD=1 -> Sel sequence 0, 1, 2, ..., 15, 0 with Enable alternating 1, 0.
REQ-032 Owner Sel=5 drops Req[5] mid-tenure while Req[9]=1 -> Enable=0 next cycle (GAP), then Sel=9 with Grant=16'h0200.
REQ-033 Reset asserted on the 2nd OWN cycle of Sel=7 -> Enable, Grant and Busy are 0 before the next edge; after release with Req=16'h0080, Sel=7 is granted one cycle later.
REQ-034 Req=0 in GAP -> IDLE next cycle with Busy=0; a later Req=16'h0400 -> Sel=10 granted one cycle later.
